// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the memory bus arbiter: FSM
//             state encoding, owner codes, grant-history codes and default
//             bus widths.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Default bus widths
  localparam int C_AW = 32;
  localparam int C_DW = 32;

  // Arbiter FSM states. The encoding deliberately matches the owner codes
  // so the debug owner output is a direct view of the state register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD_I = 2'b01,
    ST_RD_D = 2'b10,
    ST_WR_D = 2'b11
  } state_t;

  // Owner codes presented on the owner output and used for channel muxing
  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_FETCH = 2'b01;
  localparam logic [1:0] OWN_DRD   = 2'b10;
  localparam logic [1:0] OWN_DWR   = 2'b11;

  // Requester class that won the most recent grant
  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  // Owner code implied by a registered state; unknown encodings map to none
  function automatic logic [1:0] state_to_owner(input state_t s);
    logic [1:0] own;
    own = OWN_NONE;
    case (s)
      ST_RD_I: own = OWN_FETCH;
      ST_RD_D: own = OWN_DRD;
      ST_WR_D: own = OWN_DWR;
      default: own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pick
//  Purpose  : Combinational winner select between the fetch, data-read and
//             data-write requesters. Within the data class a read always
//             beats a write. Between fetch and data the choice is fixed
//             priority (data first) by default, or round-robin on the
//             grant history when MEM_ARB_RR_EN is defined.
//  Options  : MEM_ARB_RR_EN - round-robin fetch/data arbitration
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req_fetch,
  input  logic       req_drd,
  input  logic       req_dwr,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       last_grant_nxt
);

  logic w_req_data;
  logic w_data_wins;
  logic [1:0] w_data_own;

  assign w_req_data = req_drd | req_dwr;

  // Read beats write inside the data class
  assign w_data_own = req_drd ? OWN_DRD : OWN_DWR;

`ifdef MEM_ARB_RR_EN
  // On a fetch/data tie the class that did not win last time goes first
  assign w_data_wins = w_req_data & (~req_fetch | (last_grant == GRANT_FETCH));
`else
  // Data always takes precedence over fetch
  assign w_data_wins = w_req_data;
`endif

  // Final winner code and the grant history it would leave behind
  always_comb begin
    grant          = OWN_NONE;
    last_grant_nxt = last_grant;
    if (w_data_wins) begin
      grant          = w_data_own;
      last_grant_nxt = GRANT_DATA;
    end else if (req_fetch) begin
      grant          = OWN_FETCH;
      last_grant_nxt = GRANT_FETCH;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Shares one AXI4-Lite style master port between the read-only
//             instruction-fetch requester (i_*) and the read/write load-store
//             requester (d_*). One owner at a time; ownership is held until
//             the owner's final R or B handshake and is never pre-empted.
//             The winner is chosen combinationally in IDLE so a transaction
//             can start (and even finish) in the grant cycle.
//  Options  : MEM_ARB_RR_EN - round-robin fetch/data arbitration
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = C_AW,
  parameter int DW = C_DW
) (
  input  logic            clock,
  input  logic            resetn,
  // Fetch read channels
  input  logic            i_arvalid,
  input  logic [2:0]      i_arprot,
  input  logic [AW-1:0]   i_araddr,
  output logic            i_arready,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            i_rready,
  // Data read channels
  input  logic            d_arvalid,
  input  logic [2:0]      d_arprot,
  input  logic [AW-1:0]   d_araddr,
  output logic            d_arready,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  input  logic            d_rready,
  // Data write channels
  input  logic            d_awvalid,
  input  logic [2:0]      d_awprot,
  input  logic [AW-1:0]   d_awaddr,
  input  logic            d_wvalid,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_awready,
  output logic            d_wready,
  output logic            d_bvalid,
  input  logic            d_bready,
  // System bus master port
  output logic            m_arvalid,
  output logic [2:0]      m_arprot,
  output logic [AW-1:0]   m_araddr,
  input  logic            m_arready,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            m_rready,
  output logic            m_awvalid,
  output logic [2:0]      m_awprot,
  output logic [AW-1:0]   m_awaddr,
  input  logic            m_awready,
  output logic            m_wvalid,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic            m_wready,
  input  logic            m_bvalid,
  output logic            m_bready,
  // Debug / performance view of the registered owner
  output logic [1:0]      owner
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_aw_done;
  logic       w_aw_done_nxt;
  logic       r_w_done;
  logic       w_w_done_nxt;
  logic       r_last_grant;
  logic       w_last_grant_nxt;
  logic       w_pick_last_grant;
  logic [1:0] w_pick;
  logic [1:0] w_own;
  logic       w_r_hs;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_b_hs;

  mem_arb_pick u_pick (
    .req_fetch      (i_arvalid),
    .req_drd        (d_arvalid),
    .req_dwr        (d_awvalid | d_wvalid),
    .last_grant     (r_last_grant),
    .grant          (w_pick),
    .last_grant_nxt (w_pick_last_grant)
  );

  // Effective owner this cycle: the live pick in IDLE, otherwise the
  // registered owner; nothing is forwarded while reset is held
  always_comb begin
    w_own = OWN_NONE;
    if (!resetn) begin
      w_own = OWN_NONE;
    end else if (r_state == ST_IDLE) begin
      w_own = w_pick;
    end else begin
      w_own = state_to_owner(r_state);
    end
  end

  // Route the owner's requests to the bus and the bus responses back to it
  always_comb begin
    m_arvalid = 1'b0;
    m_arprot  = 3'b000;
    m_araddr  = '0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_awprot  = 3'b000;
    m_awaddr  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_bready  = 1'b0;
    i_arready = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    d_arready = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_awready = 1'b0;
    d_wready  = 1'b0;
    d_bvalid  = 1'b0;
    case (w_own)
      OWN_FETCH: begin
        m_arvalid = i_arvalid;
        m_arprot  = i_arprot;
        m_araddr  = i_araddr;
        m_rready  = i_rready;
        i_arready = m_arready;
        i_rvalid  = m_rvalid;
        i_rdata   = m_rdata;
      end
      OWN_DRD: begin
        m_arvalid = d_arvalid;
        m_arprot  = d_arprot;
        m_araddr  = d_araddr;
        m_rready  = d_rready;
        d_arready = m_arready;
        d_rvalid  = m_rvalid;
        d_rdata   = m_rdata;
      end
      OWN_DWR: begin
        // Once a channel has handshaken it is masked until release
        m_awvalid = d_awvalid & ~r_aw_done;
        m_awprot  = d_awprot;
        m_awaddr  = d_awaddr;
        m_wvalid  = d_wvalid & ~r_w_done;
        m_wdata   = d_wdata;
        m_wstrb   = d_wstrb;
        m_bready  = d_bready;
        d_awready = m_awready & ~r_aw_done;
        d_wready  = m_wready & ~r_w_done;
        d_bvalid  = m_bvalid;
      end
      default: ;
    endcase
  end

  assign w_r_hs  = m_rvalid & m_rready;
  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid & m_wready;
  assign w_b_hs  = m_bvalid & m_bready;

  // Next-state, write-progress flags and grant history
  always_comb begin
    w_state_nxt      = r_state;
    w_aw_done_nxt    = r_aw_done;
    w_w_done_nxt     = r_w_done;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        w_last_grant_nxt = w_pick_last_grant;
        w_aw_done_nxt    = 1'b0;
        w_w_done_nxt     = 1'b0;
        case (w_pick)
          // A transaction that completes in the grant cycle never
          // registers ownership
          OWN_FETCH: if (!w_r_hs) w_state_nxt = ST_RD_I;
          OWN_DRD:   if (!w_r_hs) w_state_nxt = ST_RD_D;
          OWN_DWR: begin
            if (!w_b_hs) begin
              w_state_nxt   = ST_WR_D;
              w_aw_done_nxt = w_aw_hs;
              w_w_done_nxt  = w_w_hs;
            end
          end
          default: ;
        endcase
      end
      ST_RD_I, ST_RD_D: begin
        if (w_r_hs) w_state_nxt = ST_IDLE;
      end
      ST_WR_D: begin
        w_aw_done_nxt = r_aw_done | w_aw_hs;
        w_w_done_nxt  = r_w_done | w_w_hs;
        if (w_b_hs) begin
          w_state_nxt   = ST_IDLE;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_aw_done_nxt = 1'b0;
        w_w_done_nxt  = 1'b0;
      end
    endcase
  end

  // State, flag and history registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_last_grant <= GRANT_FETCH;
    end else begin
      r_state      <= w_state_nxt;
      r_aw_done    <= w_aw_done_nxt;
      r_w_done     <= w_w_done_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  assign owner = state_to_owner(r_state);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed self-checking bench for mem_bus_arbiter. Inputs change
//             1 ns after the rising edge and outputs are compared 1 ns later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clock;
  logic        resetn;
  logic        i_arvalid, i_arready, i_rvalid, i_rready;
  logic [2:0]  i_arprot;
  logic [31:0] i_araddr, i_rdata;
  logic        d_arvalid, d_arready, d_rvalid, d_rready;
  logic [2:0]  d_arprot, d_awprot;
  logic [31:0] d_araddr, d_rdata, d_awaddr, d_wdata;
  logic        d_awvalid, d_wvalid, d_awready, d_wready, d_bvalid, d_bready;
  logic [3:0]  d_wstrb;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [2:0]  m_arprot, m_awprot;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [3:0]  m_wstrb;
  logic [1:0]  owner;

  int n_cmp;
  int n_err;

  mem_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clock(clock), .resetn(resetn),
    .i_arvalid(i_arvalid), .i_arprot(i_arprot), .i_araddr(i_araddr),
    .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_arprot(d_arprot), .d_araddr(d_araddr),
    .d_arready(d_arready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rready(d_rready),
    .d_awvalid(d_awvalid), .d_awprot(d_awprot), .d_awaddr(d_awaddr),
    .d_wvalid(d_wvalid), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_awready(d_awready), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .m_arvalid(m_arvalid), .m_arprot(m_arprot), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awprot(m_awprot), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    i_arvalid = 0; i_arprot = 0; i_araddr = 0; i_rready = 0;
    d_arvalid = 0; d_arprot = 0; d_araddr = 0; d_rready = 0;
    d_awvalid = 0; d_awprot = 0; d_awaddr = 0;
    d_wvalid = 0; d_wdata = 0; d_wstrb = 0; d_bready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0;
  endtask

  initial begin
    logic [1:0] exp_own;
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    clear_inputs();
    tick();
    tick();

    // Reset state
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_m_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("rst_m_awvalid", {31'd0, m_awvalid}, 32'd0);
    chk("rst_m_araddr", m_araddr, 32'd0);
    resetn = 1'b1;
    tick();

    // 1: fetch read with AR and R in the grant cycle
    i_arvalid = 1; i_araddr = 32'h100; i_rready = 1;
    m_arready = 1; m_rvalid = 1; m_rdata = 32'h13;
    #1;
    chk("t1_m_araddr", m_araddr, 32'h100);
    chk("t1_i_arready", {31'd0, i_arready}, 32'd1);
    chk("t1_i_rdata", i_rdata, 32'h13);
    chk("t1_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("t1_owner", {30'd0, owner}, 32'd0);
    tick();
    clear_inputs();
    #1;
    chk("t1_owner_after", {30'd0, owner}, 32'd0);
    tick();

    // 2: fetch and data-read collide; data wins, fetch follows
    i_arvalid = 1; i_araddr = 32'h100; i_rready = 1;
    d_arvalid = 1; d_araddr = 32'h2000; d_rready = 1;
    m_arready = 1;
    #1;
    chk("t2_m_araddr", m_araddr, 32'h2000);
    chk("t2_i_arready", {31'd0, i_arready}, 32'd0);
    chk("t2_d_arready", {31'd0, d_arready}, 32'd1);
    tick();
    d_arvalid = 0; m_arready = 0;
    #1;
    chk("t2_owner_drd", {30'd0, owner}, 32'd2);
    chk("t2_i_arready_wait", {31'd0, i_arready}, 32'd0);
    tick();
    tick();
    m_rvalid = 1; m_rdata = 32'hCAFE0001;
    #1;
    chk("t2_d_rdata", d_rdata, 32'hCAFE0001);
    chk("t2_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    tick();
    m_rvalid = 0; m_rdata = 0; m_arready = 1;
    #1;
    chk("t2_owner_idle", {30'd0, owner}, 32'd0);
    chk("t2_fetch_araddr", m_araddr, 32'h100);
    chk("t2_fetch_arready", {31'd0, i_arready}, 32'd1);
    tick();
    i_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'h55AA;
    #1;
    chk("t2_owner_fetch", {30'd0, owner}, 32'd1);
    chk("t2_i_rdata", i_rdata, 32'h55AA);
    tick();
    clear_inputs();
    #1;
    chk("t2_release", {30'd0, owner}, 32'd0);
    tick();

    // 3: write with staggered AW, W and B handshakes
    d_awvalid = 1; d_wvalid = 1; d_awaddr = 32'h3004;
    d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; d_bready = 1;
    #1;
    chk("t3_c0_awaddr", m_awaddr, 32'h3004);
    chk("t3_c0_wdata", m_wdata, 32'hDEADBEEF);
    chk("t3_c0_wstrb", {28'd0, m_wstrb}, 32'hF);
    tick();
    m_awready = 1;
    #1;
    chk("t3_c1_owner", {30'd0, owner}, 32'd3);
    chk("t3_c1_awvalid", {31'd0, m_awvalid}, 32'd1);
    tick();
    m_awready = 0;
    #1;
    chk("t3_c2_awvalid", {31'd0, m_awvalid}, 32'd0);
    chk("t3_c2_wvalid", {31'd0, m_wvalid}, 32'd1);
    tick();
    m_wready = 1;
    #1;
    chk("t3_c3_wready", {31'd0, d_wready}, 32'd1);
    tick();
    m_wready = 0;
    #1;
    chk("t3_c4_wvalid", {31'd0, m_wvalid}, 32'd0);
    chk("t3_c4_awready", {31'd0, d_awready}, 32'd0);
    tick();
    m_bvalid = 1;
    #1;
    chk("t3_c5_bvalid", {31'd0, d_bvalid}, 32'd1);
    chk("t3_c5_owner", {30'd0, owner}, 32'd3);
    tick();
    clear_inputs();
    #1;
    chk("t3_c6_owner", {30'd0, owner}, 32'd0);
    tick();

    // 6: data read and write together; read first, write held off
    d_arvalid = 1; d_araddr = 32'h4000; d_rready = 1;
    d_awvalid = 1; d_wvalid = 1; d_awaddr = 32'h5000; d_wdata = 32'h1234; d_wstrb = 4'h3; d_bready = 1;
    m_arready = 1; m_awready = 1; m_wready = 1;
    #1;
    chk("t6_m_arvalid", {31'd0, m_arvalid}, 32'd1);
    chk("t6_m_awvalid", {31'd0, m_awvalid}, 32'd0);
    chk("t6_d_awready", {31'd0, d_awready}, 32'd0);
    tick();
    d_arvalid = 0; m_arready = 0; m_rvalid = 1;
    #1;
    chk("t6_owner_drd", {30'd0, owner}, 32'd2);
    chk("t6_rd_awvalid", {31'd0, m_awvalid}, 32'd0);
    chk("t6_rd_wvalid", {31'd0, m_wvalid}, 32'd0);
    tick();
    m_rvalid = 0; m_bvalid = 1;
    #1;
    chk("t6_wr_owner", {30'd0, owner}, 32'd0);
    chk("t6_wr_awaddr", m_awaddr, 32'h5000);
    chk("t6_wr_bvalid", {31'd0, d_bvalid}, 32'd1);
    tick();
    clear_inputs();
    #1;
    chk("t6_wr_same_cycle", {30'd0, owner}, 32'd0);
    tick();

    // 5: reset while a data read is outstanding
    d_arvalid = 1; d_araddr = 32'h6000; d_rready = 1; m_arready = 1;
    tick();
    m_arready = 0;
    #1;
    chk("t5_owner_drd", {30'd0, owner}, 32'd2);
    resetn = 0;
    tick();
    chk("t5_owner", {30'd0, owner}, 32'd0);
    chk("t5_m_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("t5_m_rready", {31'd0, m_rready}, 32'd0);
    chk("t5_d_arready", {31'd0, d_arready}, 32'd0);
    resetn = 1;
    clear_inputs();
    tick();

    // 4: fetch and data requesting continuously for six transactions
    i_arvalid = 1; i_araddr = 32'h100; i_rready = 1;
    d_arvalid = 1; d_araddr = 32'h2000; d_rready = 1;
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_own = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_own = 2'b10;
`endif
      m_arready = 1; m_rvalid = 0;
      #1;
      chk("t4_grant_addr", m_araddr, (exp_own == 2'b10) ? 32'h2000 : 32'h100);
      tick();
      m_arready = 0; m_rvalid = 1;
      #1;
      chk("t4_owner", {30'd0, owner}, {30'd0, exp_own});
      tick();
    end
    clear_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound on simulation time
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
